lif_layer: RTL and testbench
============================

// Module: lif_layer
// PURPOSE
// - Parallel layer of NUM_NEURONS leaky integrate-and-fire neurons; generalised successor of the single-neuron LIF.
// - Parametrised widths, runtime beta/threshold, selectable reset mechanism (subtract or zero), saturating membrane.
// - Sits between a dense layer's current outputs and the spike accumulator/decoder of the SNN inference pipeline.
// - One timestep per clock after start; per-neuron spikes and membranes emitted each timestep with valid.
// PARAMETERS
// - NUM_NEURONS   4     neurons in the layer (>=1)
// - DATA_W        16    input current width, signed QS2.13 at default
// - MEM_W         24    membrane width, signed, same fractional bits as current (MEM_W >= DATA_W+2)
// - BETA_W        8     beta width, unsigned
// - BETA_FRAC     7     fractional bits of beta (115 = ~0.9)
// - NUM_TIMESTEPS 30    timesteps per inference (>=2)
// PORTS
// - clk          in   1                  rising-edge clock
// - reset        in   1                  asynchronous, active-high
// - start        in   1                  begin inference; honoured only when busy=0
// - current      in   NUM_NEURONS*DATA_W signed currents, neuron n at [n*DATA_W +: DATA_W]
// - beta         in   BETA_W             decay factor, sampled with start
// - threshold    in   MEM_W              signed spike threshold (>0), sampled with start
// - reset_zero   in   1                  0: subtract-threshold reset; 1: reset-to-zero; sampled with start
// - busy         out  1                  inference in progress
// - valid        out  1                  spike_out/membrane_out/timestep hold timestep results
// - spike_out    out  NUM_NEURONS        spike per neuron for current timestep
// - membrane_out out  NUM_NEURONS*MEM_W  membrane per neuron, same packing as current
// - timestep     out  $clog2(NUM_TIMESTEPS) index of presented timestep
// - done         out  1                  inference complete; held until next accepted start
// - spike_count  out  NUM_NEURONS*$clog2(NUM_TIMESTEPS+1)  (only with LIF_LAYER_SPIKE_COUNT_EN)
// BEHAVIOUR
// - Reset (any time, incl. mid-inference): state IDLE; busy/valid/done/spike_out=0, membrane_out=0, timestep=0,
//   internal membranes, spike_prev, latched config and counters =0. Aborted run produces no done.
// - FSM: IDLE --start--> RUN --last timestep--> DONE --start--> RUN. start while RUN ignored (no relatch).
// - Accepting start at edge k: latch current/beta/threshold/reset_zero; membranes start at 0, spike_prev=0;
//   timestep 0 computed from the live inputs in that same cycle; after edge k: busy=1, valid=1, timestep=0, done=0.
// - Timestep t presented after edge k+t, t=0..NUM_TIMESTEPS-1; uses latched values for t>=1.
// - After edge k+NUM_TIMESTEPS: valid=0, busy=0, done=1; spike_out/membrane_out hold last timestep values.
// - start accepted in DONE at edge k+NUM_TIMESTEPS+1 earliest (back-to-back, no extra idle cycle required).
// - Per neuron, per timestep (all arithmetic signed, sign-extended to MEM_W+BETA_W+1 before multiply):
//   decay = (mem * {0,beta}) >>> BETA_FRAC (arithmetic shift, rounds toward -inf);
//   subtract mode: next = decay + I - (spike_prev ? threshold : 0);
//   zero mode:     next = (spike_prev ? 0 : decay) + I;
//   next saturates to [-2^(MEM_W-1), 2^(MEM_W-1)-1], never wraps.
//   spike = (next >= threshold); mem <= next; spike_prev <= spike (reset applied one timestep later).
// - All neurons update in the same cycle; no inter-neuron dependency.
// CONFIGURATION
// - LIF_LAYER_SPIKE_COUNT_EN defined: spike_count port exists; per-neuron counter cleared on accepted start,
//   +1 per spiking timestep (timestep 0 included), final value stable while done=1, reset to 0.
// - Not defined: port and counters absent; all other behaviour identical.
// TESTING (NUM_NEURONS=4, defaults unless stated; beta=115, threshold=8192)
// - Subtract mode, current=4096 all -> membranes t0..t3 = 4096, 7776, 11082, 5860; spike only at t2 among t0..t3.
// - Zero mode, same stimulus -> t2 = 11082 spike, t3 = 4096 (decay discarded after spike).
// - Mixed lanes {4096, -8192, 0, 16384} -> lane1 t0=-8192, t1=-15552, never spikes; lane2 stays 0; lane3 spikes at t0.
// - Timing: start at edge k -> valid 1 for exactly NUM_TIMESTEPS cycles, timestep 0..29; done=1 after edge k+30;
//   start held high during RUN ignored; new start in DONE restarts with done cleared next edge.
// - MEM_W=18, beta=127, current=32767, threshold=131071 -> membrane_out clamps at 131071, never goes negative.
// - Reset asserted at t=10 -> all outputs 0 asynchronously; no done; next start yields t0 identical to fresh run.

Source files
------------

// File: rtl/lif_layer.sv
// lif_layer: a layer of NUM_NEURONS leaky integrate-and-fire neurons, one timestep per clock.
// Define LIF_LAYER_SPIKE_COUNT_EN to add per-neuron spike counters on the spike_count port.
module lif_layer #(
    parameter int NUM_NEURONS   = 4,
    parameter int DATA_W        = 16,
    parameter int MEM_W         = 24,
    parameter int BETA_W        = 8,
    parameter int BETA_FRAC     = 7,
    parameter int NUM_TIMESTEPS = 30
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [NUM_NEURONS*DATA_W-1:0]         current,
    input  logic [BETA_W-1:0]                     beta,
    input  logic [MEM_W-1:0]                      threshold,
    input  logic                                  reset_zero,
    output logic                                  busy,
    output logic                                  valid,
    output logic [NUM_NEURONS-1:0]                spike_out,
    output logic [NUM_NEURONS*MEM_W-1:0]          membrane_out,
    output logic [$clog2(NUM_TIMESTEPS)-1:0]      timestep,
    output logic                                  done,
`ifdef LIF_LAYER_SPIKE_COUNT_EN
    output logic [NUM_NEURONS*$clog2(NUM_TIMESTEPS+1)-1:0] spike_count,
`endif
    output logic [1:0]                            fsm_state
);
    // Handshake: start is a level sampled on a rising edge; it is accepted whenever the
    // layer is not running. valid is high for exactly NUM_TIMESTEPS cycles per accepted start.
    localparam int TS_W = $clog2(NUM_TIMESTEPS);
    localparam int EW   = MEM_W + BETA_W + 1;
    localparam int SW   = EW + 2;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [TS_W-1:0] LAST_TS = TS_W'(NUM_TIMESTEPS - 1);
    localparam logic signed [SW-1:0] MEM_MAX = {{(SW-MEM_W+1){1'b0}}, {(MEM_W-1){1'b1}}};
    localparam logic signed [SW-1:0] MEM_MIN = {{(SW-MEM_W+1){1'b1}}, {(MEM_W-1){1'b0}}};

    logic [1:0]                    state;
    logic [NUM_NEURONS*DATA_W-1:0] current_q;
    logic [BETA_W-1:0]             beta_q;
    logic [MEM_W-1:0]              threshold_q;
    logic                          reset_zero_q;
    logic                          accept;
    logic [NUM_NEURONS*DATA_W-1:0] cur_sel;
    logic [BETA_W-1:0]             beta_sel;
    logic [MEM_W-1:0]              thr_sel;
    logic                          rz_sel;
    logic [MEM_W-1:0]              nxt_mem [NUM_NEURONS];
    logic [NUM_NEURONS-1:0]        nxt_spk;

    assign accept    = start && (state != S_RUN);
    assign fsm_state = state;

    // Timestep 0 is computed in the accepting cycle straight from the live inputs.
    assign cur_sel  = accept ? current    : current_q;
    assign beta_sel = accept ? beta       : beta_q;
    assign thr_sel  = accept ? threshold  : threshold_q;
    assign rz_sel   = accept ? reset_zero : reset_zero_q;

    for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
        logic signed [MEM_W-1:0] mem_cur;
        logic                    spk_cur;
        logic signed [EW-1:0]    mem_x, beta_x, prod, decay;
        logic signed [SW-1:0]    decay_x, cur_x, thr_x, sum;
        logic signed [MEM_W-1:0] sat;

        assign mem_cur = accept ? '0 : membrane_out[n*MEM_W +: MEM_W];
        assign spk_cur = accept ? 1'b0 : spike_out[n];
        assign mem_x   = {{(EW-MEM_W){mem_cur[MEM_W-1]}}, mem_cur};
        assign beta_x  = {{(EW-BETA_W){1'b0}}, beta_sel};
        assign prod    = mem_x * beta_x;
        assign decay   = prod >>> BETA_FRAC;
        assign decay_x = {{(SW-EW){decay[EW-1]}}, decay};
        assign cur_x   = {{(SW-DATA_W){cur_sel[n*DATA_W+DATA_W-1]}}, cur_sel[n*DATA_W +: DATA_W]};
        assign thr_x   = {{(SW-MEM_W){thr_sel[MEM_W-1]}}, thr_sel};

        always_comb begin
            if (rz_sel)
                sum = (spk_cur ? '0 : decay_x) + cur_x;
            else
                sum = decay_x + cur_x - (spk_cur ? thr_x : '0);
            if (sum > MEM_MAX)
                sat = MEM_MAX[MEM_W-1:0];
            else if (sum < MEM_MIN)
                sat = MEM_MIN[MEM_W-1:0];
            else
                sat = sum[MEM_W-1:0];
        end

        assign nxt_mem[n] = sat;
        assign nxt_spk[n] = (sat >= $signed(thr_sel));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            valid        <= 1'b0;
            done         <= 1'b0;
            timestep     <= '0;
            spike_out    <= '0;
            membrane_out <= '0;
            current_q    <= '0;
            beta_q       <= '0;
            threshold_q  <= '0;
            reset_zero_q <= 1'b0;
        end else if (accept) begin
            state        <= S_RUN;
            busy         <= 1'b1;
            valid        <= 1'b1;
            done         <= 1'b0;
            timestep     <= '0;
            current_q    <= current;
            beta_q       <= beta;
            threshold_q  <= threshold;
            reset_zero_q <= reset_zero;
            spike_out    <= nxt_spk;
            for (int n = 0; n < NUM_NEURONS; n++)
                membrane_out[n*MEM_W +: MEM_W] <= nxt_mem[n];
        end else if (state == S_RUN) begin
            if (timestep == LAST_TS) begin
                // Results of the final timestep stay on the outputs while done is high.
                state <= S_DONE;
                busy  <= 1'b0;
                valid <= 1'b0;
                done  <= 1'b1;
            end else begin
                timestep  <= timestep + TS_W'(1);
                spike_out <= nxt_spk;
                for (int n = 0; n < NUM_NEURONS; n++)
                    membrane_out[n*MEM_W +: MEM_W] <= nxt_mem[n];
            end
        end
    end

`ifdef LIF_LAYER_SPIKE_COUNT_EN
    localparam int CNT_W = $clog2(NUM_TIMESTEPS + 1);
    logic [CNT_W-1:0] cnt [NUM_NEURONS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < NUM_NEURONS; n++)
                cnt[n] <= '0;
        end else if (accept) begin
            for (int n = 0; n < NUM_NEURONS; n++)
                cnt[n] <= CNT_W'(nxt_spk[n]);
        end else if (state == S_RUN && timestep != LAST_TS) begin
            for (int n = 0; n < NUM_NEURONS; n++)
                cnt[n] <= cnt[n] + CNT_W'(nxt_spk[n]);
        end
    end

    for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_count
        assign spike_count[n*CNT_W +: CNT_W] = cnt[n];
    end
`endif

endmodule

// File: tb/tb_lif_layer.sv
// Bench for lif_layer: two instances (MEM_W=24 and MEM_W=18) driven together and
// compared every timestep against a plain-arithmetic reference model.
module tb_lif_layer;
  localparam int NN  = 4;
  localparam int DW  = 16;
  localparam int MWA = 24;
  localparam int MWB = 18;
  localparam int NT  = 30;
  localparam int TSW = 5;

  logic clk = 1'b0;
  logic reset, start, reset_zero;
  logic [NN*DW-1:0] current;
  logic [7:0] beta;
  logic [MWA-1:0] thr_a;
  logic [MWB-1:0] thr_b;

  logic busy_a, valid_a, done_a, busy_b, valid_b, done_b;
  logic [NN-1:0] spike_a, spike_b;
  logic [NN*MWA-1:0] mem_a;
  logic [NN*MWB-1:0] mem_b;
  logic [TSW-1:0] ts_a, ts_b;
  logic [1:0] state_a, state_b;
`ifdef LIF_LAYER_SPIKE_COUNT_EN
  logic [NN*5-1:0] cnt_a, cnt_b;
`endif

  lif_layer #(.NUM_NEURONS(NN), .DATA_W(DW), .MEM_W(MWA)) dut_a (
    .clk(clk), .reset(reset), .start(start), .current(current), .beta(beta),
    .threshold(thr_a), .reset_zero(reset_zero), .busy(busy_a), .valid(valid_a),
    .spike_out(spike_a), .membrane_out(mem_a), .timestep(ts_a), .done(done_a),
`ifdef LIF_LAYER_SPIKE_COUNT_EN
    .spike_count(cnt_a),
`endif
    .fsm_state(state_a)
  );

  lif_layer #(.NUM_NEURONS(NN), .DATA_W(DW), .MEM_W(MWB)) dut_b (
    .clk(clk), .reset(reset), .start(start), .current(current), .beta(beta),
    .threshold(thr_b), .reset_zero(reset_zero), .busy(busy_b), .valid(valid_b),
    .spike_out(spike_b), .membrane_out(mem_b), .timestep(ts_b), .done(done_b),
`ifdef LIF_LAYER_SPIKE_COUNT_EN
    .spike_count(cnt_b),
`endif
    .fsm_state(state_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  longint exp_mem [2][NT][NN];
  bit     exp_spk [2][NT][NN];
  longint obs_mem [NT][NN];
  bit     obs_spk [NT][NN];
  longint max_b, min_b;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint lane_a(input int n);
    logic [MWA-1:0] v;
    v = mem_a[n*MWA +: MWA];
    return longint'($signed(v));
  endfunction

  function automatic longint lane_b(input int n);
    logic [MWB-1:0] v;
    v = mem_b[n*MWB +: MWB];
    return longint'($signed(v));
  endfunction

  // Reference: whole-inference trajectory from the neuron equations in 64-bit arithmetic.
  task automatic model_run(input int sel, input longint cur[NN], input int b,
                           input longint thr, input bit rz, input int mw);
    longint m[NN];
    bit sp[NN];
    longint hi, lo, d, nx;
    hi = (64'sd1 <<< (mw - 1)) - 1;
    lo = -hi - 1;
    for (int n = 0; n < NN; n++) begin
      m[n] = 0;
      sp[n] = 0;
    end
    for (int t = 0; t < NT; t++) begin
      for (int n = 0; n < NN; n++) begin
        d = (m[n] * b) >>> 7;  // floor(mem*beta/128)
        if (rz) nx = (sp[n] ? 0 : d) + cur[n];
        else    nx = d + cur[n] - (sp[n] ? thr : 0);
        if (nx > hi) nx = hi;
        if (nx < lo) nx = lo;
        m[n] = nx;
        sp[n] = (nx >= thr);
        exp_mem[sel][t][n] = nx;
        exp_spk[sel][t][n] = sp[n];
      end
    end
  endtask

  task automatic drive_cfg(input longint cur[NN], input int b, input longint thr, input bit rz);
    for (int n = 0; n < NN; n++) current[n*DW +: DW] = 16'(cur[n]);
    beta = 8'(b);
    thr_a = 24'(thr);
    thr_b = 18'(thr);
    reset_zero = rz;
  endtask

  task automatic run_inference(input longint cur[NN], input int b, input longint thr,
                               input bit rz, input bit hold);
    longint g;
    model_run(0, cur, b, thr, rz, MWA);
    model_run(1, cur, b, thr, rz, MWB);
    drive_cfg(cur, b, thr, rz);
    start = 1'b1;
    max_b = -(64'sd1 <<< 40);
    min_b = (64'sd1 <<< 40);
    for (int t = 0; t < NT; t++) begin
      @(posedge clk); #1;
      if (!hold || t == NT - 1) start = 1'b0;
      // Live inputs change while running; only the values latched with start may matter.
      current = {$urandom, $urandom};
      beta = 8'($urandom);
      thr_a = 24'($urandom);
      thr_b = 18'($urandom);
      reset_zero = 1'($urandom);
      check($sformatf("valid t%0d", t), valid_a, 1);
      check($sformatf("busy t%0d", t), busy_a, 1);
      check($sformatf("done t%0d", t), done_a, 0);
      check($sformatf("timestep t%0d", t), ts_a, t);
      check($sformatf("state t%0d", t), state_a, 1);
      check($sformatf("valid_b t%0d", t), valid_b, 1);
      for (int n = 0; n < NN; n++) begin
        g = lane_a(n);
        obs_mem[t][n] = g;
        obs_spk[t][n] = spike_a[n];
        check($sformatf("mem_a t%0d n%0d", t, n), g, exp_mem[0][t][n]);
        check($sformatf("spk_a t%0d n%0d", t, n), spike_a[n], exp_spk[0][t][n]);
        g = lane_b(n);
        if (g > max_b) max_b = g;
        if (g < min_b) min_b = g;
        check($sformatf("mem_b t%0d n%0d", t, n), g, exp_mem[1][t][n]);
        check($sformatf("spk_b t%0d n%0d", t, n), spike_b[n], exp_spk[1][t][n]);
      end
    end
    @(posedge clk); #1;
    check("end valid", valid_a, 0);
    check("end busy", busy_a, 0);
    check("end done", done_a, 1);
    check("end state", state_a, 2);
    check("end done_b", done_b, 1);
    for (int n = 0; n < NN; n++) begin
      int sum;
      check($sformatf("hold mem n%0d", n), lane_a(n), exp_mem[0][NT-1][n]);
      check($sformatf("hold spk n%0d", n), spike_a[n], exp_spk[0][NT-1][n]);
`ifdef LIF_LAYER_SPIKE_COUNT_EN
      sum = 0;
      for (int t = 0; t < NT; t++) sum += exp_spk[0][t][n];
      check($sformatf("count_a n%0d", n), cnt_a[n*5 +: 5], sum);
      sum = 0;
      for (int t = 0; t < NT; t++) sum += exp_spk[1][t][n];
      check($sformatf("count_b n%0d", n), cnt_b[n*5 +: 5], sum);
`else
      sum = n;
`endif
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, busy_a, 0);
    check({tag, " valid"}, valid_a, 0);
    check({tag, " done"}, done_a, 0);
    check({tag, " spike"}, spike_a, 0);
    check({tag, " mem"}, (mem_a == '0) ? 0 : 1, 0);
    check({tag, " timestep"}, ts_a, 0);
    check({tag, " state"}, state_a, 0);
    check({tag, " mem_b"}, (mem_b == '0) ? 0 : 1, 0);
  endtask

  initial begin
    longint c[NN];
    longint keep[NN];
    bit any;

    reset = 1'b1;
    start = 1'b0;
    current = '0;
    beta = '0;
    thr_a = '0;
    thr_b = '0;
    reset_zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Subtract mode, uniform current.
    c = '{4096, 4096, 4096, 4096};
    run_inference(c, 115, 8192, 1'b0, 1'b0);
    check("sub t0", obs_mem[0][0], 4096);
    check("sub t1", obs_mem[1][0], 7776);
    check("sub t2", obs_mem[2][0], 11082);
    check("sub t3", obs_mem[3][0], 5860);
    check("sub spikes t0..t3", {obs_spk[0][0], obs_spk[1][0], obs_spk[2][0], obs_spk[3][0]}, 4'b0010);

    // Zero mode, back-to-back with held start.
    run_inference(c, 115, 8192, 1'b1, 1'b1);
    check("zero t2", obs_mem[2][0], 11082);
    check("zero t2 spike", obs_spk[2][0], 1);
    check("zero t3", obs_mem[3][0], 4096);

    // Idle in DONE: results and done hold.
    repeat (3) @(posedge clk);
    #1;
    check("idle done", done_a, 1);
    check("idle mem", lane_a(0), exp_mem[0][NT-1][0]);

    // Mixed lanes.
    c = '{4096, -8192, 0, 16384};
    run_inference(c, 115, 8192, 1'b0, 1'b0);
    check("mix l1 t0", obs_mem[0][1], -8192);
    check("mix l1 t1", obs_mem[1][1], -15552);
    any = 0;
    for (int t = 0; t < NT; t++) any |= obs_spk[t][1];
    check("mix l1 never spikes", any, 0);
    any = 0;
    for (int t = 0; t < NT; t++) any |= (obs_mem[t][2] != 0);
    check("mix l2 stays zero", any, 0);
    check("mix l3 t0 spike", obs_spk[0][3], 1);

    // Saturation on the narrow instance.
    c = '{32767, 32767, 32767, 32767};
    run_inference(c, 127, 131071, 1'b0, 1'b0);
    check("sat max", max_b, 131071);
    check("sat nonneg", (min_b >= 0) ? 1 : 0, 1);
    run_inference(c, 127, 131071, 1'b1, 1'b0);
    check("sat zero max", max_b, 131071);

    // Randomized back-to-back inferences.
    for (int r = 0; r < 8; r++) begin
      for (int n = 0; n < NN; n++) c[n] = longint'($signed(16'($urandom)));
      run_inference(c, int'($urandom_range(0, 255)), longint'($urandom_range(1, 131071)),
                    1'($urandom), 1'($urandom));
    end

    // Reset in the middle of an inference.
    for (int n = 0; n < NN; n++) keep[n] = longint'($signed(16'($urandom)));
    drive_cfg(keep, 115, 8192, 1'b0);
    start = 1'b1;
    for (int t = 0; t <= 10; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("pre-abort timestep", ts_a, 10);
    #2 reset = 1'b1;
    #1;
    check_all_zero("async reset");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (NT + 5) @(posedge clk);
    #1;
    check("abort no done", done_a, 0);
    check("abort no valid", valid_a, 0);
    run_inference(keep, 115, 8192, 1'b0, 1'b0);
    check("rerun t0 lane0", obs_mem[0][0], keep[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
